// File: rtl/leaf_accum_pkg.sv
// leaf_accum_pkg: shared types and constants for leaf_accum_stage.
//   leaf_state_e  - two-state FSM encoding (ACCUM, EMIT)
//   *_DEF         - default parameter values for the stage
//   sat_add       - saturating add used when LEAF_ACCUM_SATURATE_EN is defined
package leaf_accum_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } leaf_state_e;

    localparam int unsigned DATA_W_DEF    = 8;
    localparam int unsigned SUM_W_DEF     = 12;
    localparam int unsigned BLOCK_LEN_DEF = 4;
    localparam int unsigned CNT_W_DEF     = 8;

    typedef struct packed {
        logic        ovf;
        logic [63:0] sum;
    } sat_res_t;

    // Adds a and b and clamps the result to 2^w-1 (w <= 64); ovf flags a clamp.
    function automatic sat_res_t sat_add(input logic [63:0] a,
                                         input logic [63:0] b,
                                         input int unsigned w);
        logic [64:0] full;
        logic [64:0] limit;
        sat_res_t    res;
        full  = {1'b0, a} + {1'b0, b};
        limit = (65'd1 << w) - 65'd1;
        if (full > limit) begin
            res.sum = limit[63:0];
            res.ovf = 1'b1;
        end else begin
            res.sum = full[63:0];
            res.ovf = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/leaf_accum_stage.sv
// leaf_accum_stage: accumulates a valid/ready sample stream into blocks of up
// to BLOCK_LEN beats (closed early by in_last) and emits one summary beat
// (sum, count) per block over valid/ready.
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   in_valid/in_ready   upstream sample handshake
//   in_data, in_last    sample value, early block close
//   out_valid/out_ready downstream summary handshake
//   out_sum, out_count  block sum, number of samples in block
//   out_ovf             (LEAF_ACCUM_SATURATE_EN only) a saturation occurred
//
// Build option: define LEAF_ACCUM_SATURATE_EN for a saturating accumulator
// and the out_ovf port; otherwise the sum wraps modulo 2^SUM_W.
module leaf_accum_stage
    import leaf_accum_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned SUM_W     = SUM_W_DEF,
    parameter int unsigned BLOCK_LEN = BLOCK_LEN_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count
`ifdef LEAF_ACCUM_SATURATE_EN
    ,
    output logic              out_ovf
`endif
);

    leaf_state_e      state_q;
    logic [SUM_W-1:0] acc_q;
    logic [SUM_W-1:0] acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [SUM_W-1:0] out_sum_q;
    logic [CNT_W-1:0] out_count_q;
    logic             close_blk;
`ifdef LEAF_ACCUM_SATURATE_EN
    logic             ovf_q;
    logic             ovf_d;
    logic             out_ovf_q;
    sat_res_t         sat;
`endif

    // Candidate accumulator/count including the beat currently offered.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
`ifdef LEAF_ACCUM_SATURATE_EN
        sat   = sat_add(64'(acc_q), 64'(in_data), SUM_W);
        acc_d = sat.sum[SUM_W-1:0];
        ovf_d = ovf_q | sat.ovf;
`else
        acc_d = acc_q + SUM_W'(in_data);
`endif
        // in_last on the BLOCK_LEN-th beat still closes just one block.
        close_blk = in_last || (cnt_d == CNT_W'(BLOCK_LEN));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_sum_q   <= '0;
            out_count_q <= '0;
`ifdef LEAF_ACCUM_SATURATE_EN
            ovf_q       <= 1'b0;
            out_ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_valid) begin
                        if (close_blk) begin
                            out_sum_q   <= acc_d;
                            out_count_q <= cnt_d;
                            acc_q       <= '0;
                            cnt_q       <= '0;
`ifdef LEAF_ACCUM_SATURATE_EN
                            out_ovf_q   <= ovf_d;
                            ovf_q       <= 1'b0;
`endif
                            state_q     <= EMIT;
                        end else begin
                            acc_q <= acc_d;
                            cnt_q <= cnt_d;
`ifdef LEAF_ACCUM_SATURATE_EN
                            ovf_q <= ovf_d;
`endif
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        state_q <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    // Handshake flags decode straight from the state register, so reset
    // drops out_valid (and raises in_ready) asynchronously.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == EMIT);
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
`ifdef LEAF_ACCUM_SATURATE_EN
    assign out_ovf   = out_ovf_q;
`endif

endmodule

// File: tb/tb_leaf_accum_stage.sv
// tb_leaf_accum_stage: directed-vector bench for leaf_accum_stage.
// u0: default parameters; u8: SUM_W=8 (wrap/saturate), shares u0's stimulus;
// u1: BLOCK_LEN=1 with its own stimulus.
module tb_leaf_accum_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        v0 = 1'b0;
    logic [7:0]  d0 = '0;
    logic        l0 = 1'b0;
    logic        r0 = 1'b1;
    logic        rdy0, ov0;
    logic [11:0] sum0;
    logic [7:0]  cnt0;

    logic        rdy8, ov8;
    logic [7:0]  sum8;
    logic [7:0]  cnt8;

    logic        v1 = 1'b0;
    logic [7:0]  d1 = '0;
    logic        rdy1, ov1;
    logic [11:0] sum1;
    logic [7:0]  cnt1;

`ifdef LEAF_ACCUM_SATURATE_EN
    logic        ovf0, ovf8, ovf1;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    leaf_accum_stage #(.DATA_W(8), .SUM_W(12), .BLOCK_LEN(4), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst),
        .in_valid(v0), .in_ready(rdy0), .in_data(d0), .in_last(l0),
        .out_valid(ov0), .out_ready(r0), .out_sum(sum0), .out_count(cnt0)
`ifdef LEAF_ACCUM_SATURATE_EN
        , .out_ovf(ovf0)
`endif
    );

    leaf_accum_stage #(.DATA_W(8), .SUM_W(8), .BLOCK_LEN(4), .CNT_W(8)) u8 (
        .clk(clk), .rst(rst),
        .in_valid(v0), .in_ready(rdy8), .in_data(d0), .in_last(l0),
        .out_valid(ov8), .out_ready(r0), .out_sum(sum8), .out_count(cnt8)
`ifdef LEAF_ACCUM_SATURATE_EN
        , .out_ovf(ovf8)
`endif
    );

    leaf_accum_stage #(.DATA_W(8), .SUM_W(12), .BLOCK_LEN(1), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst),
        .in_valid(v1), .in_ready(rdy1), .in_data(d1), .in_last(1'b0),
        .out_valid(ov1), .out_ready(1'b1), .out_sum(sum1), .out_count(cnt1)
`ifdef LEAF_ACCUM_SATURATE_EN
        , .out_ovf(ovf1)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; offers one beat, returns at the next negedge.
    task automatic push(input logic [7:0] d, input logic l);
        v0 = 1'b1;
        d0 = d;
        l0 = l;
        @(negedge clk);
        v0 = 1'b0;
        l0 = 1'b0;
    endtask

    task automatic check_emit(input string tag, input logic [31:0] s,
                              input logic [31:0] c);
        check_eq({tag, "_valid"}, 32'(ov0), 1);
        check_eq({tag, "_ready"}, 32'(rdy0), 0);
        check_eq({tag, "_sum"}, 32'(sum0), s);
        check_eq({tag, "_count"}, 32'(cnt0), c);
    endtask

    initial begin
        // Reset state
        #1;
        check_eq("rst_in_ready", 32'(rdy0), 1);
        check_eq("rst_out_valid", 32'(ov0), 0);
        check_eq("rst_out_sum", 32'(sum0), 0);
        check_eq("rst_out_count", 32'(cnt0), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Full block, out_ready high: EMIT lasts one cycle
        push(8'd10, 1'b0);
        push(8'd20, 1'b0);
        push(8'd30, 1'b0);
        check_eq("t1_no_early_valid", 32'(ov0), 0);
        push(8'd40, 1'b0);
        check_emit("t1", 100, 4);
        @(negedge clk);
        check_eq("t1_valid_drop", 32'(ov0), 0);
        check_eq("t1_ready_back", 32'(rdy0), 1);

        // Early close with in_last
        push(8'd5, 1'b0);
        push(8'd6, 1'b1);
        check_emit("t2", 11, 2);
        @(negedge clk);

        // Wrap (u8) / saturate; also confirms acc restarted from 0
        push(8'd200, 1'b0);
        push(8'd100, 1'b0);
        push(8'd0, 1'b0);
        push(8'd0, 1'b0);
        check_emit("t3_u0", 300, 4);
        check_eq("t3_u8_valid", 32'(ov8), 1);
`ifdef LEAF_ACCUM_SATURATE_EN
        check_eq("t3_u8_sum", 32'(sum8), 255);
        check_eq("t3_u8_ovf", 32'(ovf8), 1);
        check_eq("t3_u0_ovf", 32'(ovf0), 0);
`else
        check_eq("t3_u8_sum", 32'(sum8), 44);
`endif
        @(negedge clk);

        // in_last on the BLOCK_LEN-th beat closes a single block
        push(8'd1, 1'b0);
        push(8'd2, 1'b0);
        push(8'd3, 1'b0);
        push(8'd4, 1'b1);
        check_emit("t4", 10, 4);
        @(negedge clk);
        check_eq("t4_single_block", 32'(ov0), 0);

        // Backpressure: summary held, inputs ignored
        r0 = 1'b0;
        push(8'd2, 1'b0);
        push(8'd4, 1'b0);
        push(8'd6, 1'b0);
        push(8'd8, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check_emit($sformatf("t5_hold%0d", i), 20, 4);
            v0 = 1'b1;
            d0 = 8'd99;
            @(negedge clk);
        end
        check_emit("t5_last", 20, 4);
        v0 = 1'b0;
        r0 = 1'b1;
        @(negedge clk);
        check_eq("t5_released", 32'(ov0), 0);
        push(8'd1, 1'b1);
        check_emit("t5_no_leak", 1, 1);
        @(negedge clk);

        // Reset during EMIT drops the summary asynchronously
        r0 = 1'b0;
        push(8'd7, 1'b0);
        push(8'd9, 1'b1);
        check_emit("t6_pre", 16, 2);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_valid_async", 32'(ov0), 0);
        check_eq("t6_sum_clr", 32'(sum0), 0);
        check_eq("t6_count_clr", 32'(cnt0), 0);
        check_eq("t6_ready_async", 32'(rdy0), 1);
        @(negedge clk);
        rst = 1'b0;
        r0 = 1'b1;

        // Reset mid-block discards the partial sum
        push(8'd7, 1'b0);
        push(8'd9, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push(8'd1, 1'b0);
        push(8'd1, 1'b0);
        push(8'd1, 1'b0);
        push(8'd1, 1'b0);
        check_emit("t7", 4, 4);
        @(negedge clk);

        // BLOCK_LEN=1: one accept every 2 cycles, each beat its own summary
        v1 = 1'b1;
        d1 = 8'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("t8_valid%0d", i), 32'(ov1), 1);
            check_eq($sformatf("t8_ready%0d", i), 32'(rdy1), 0);
            check_eq($sformatf("t8_sum%0d", i), 32'(sum1), 32'(3 + i));
            check_eq($sformatf("t8_count%0d", i), 32'(cnt1), 1);
            d1 = 8'(4 + i);
            @(negedge clk);
            check_eq($sformatf("t8_gap%0d", i), 32'(ov1), 0);
        end
        v1 = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
